// File: rtl/lc3_pkg.sv
// Shared definitions for the LC3 multicycle control unit: micro-state
// encoding, opcode constants, select/ALU encodings and the control bundle
// that the decoder hands to the top level.
package lc3_pkg;

    localparam int unsigned STATE_W  = 5;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned IR_W     = 16;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 5'd0,
        S_FETCH0  = 5'd1,
        S_FETCH1  = 5'd2,
        S_FETCH2  = 5'd3,
        S_DECODE  = 5'd4,
        S_ALU     = 5'd5,
        S_BR      = 5'd6,
        S_JMP     = 5'd7,
        S_JSR0    = 5'd8,
        S_JSR1    = 5'd9,
        S_LEA     = 5'd10,
        S_ADDR    = 5'd11,
        S_IND_RD  = 5'd12,
        S_IND_MAR = 5'd13,
        S_MEM_RD  = 5'd14,
        S_LD_WB   = 5'd15,
        S_ST_MDR  = 5'd16,
        S_MEM_WR  = 5'd17,
        S_HALT    = 5'd18
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_RSV  = 4'b1101;
    localparam logic [OPCODE_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_TRAP = 4'b1111;

    localparam logic [SEL_W-1:0] SELPC_INC = 2'b00;
    localparam logic [SEL_W-1:0] SELPC_EAB = 2'b01;
    localparam logic [SEL_W-1:0] SELPC_BUS = 2'b10;

    localparam logic [SEL_W-1:0] EAB2_ZERO  = 2'b00;
    localparam logic [SEL_W-1:0] EAB2_OFF6  = 2'b01;
    localparam logic [SEL_W-1:0] EAB2_OFF9  = 2'b10;
    localparam logic [SEL_W-1:0] EAB2_OFF11 = 2'b11;

    localparam logic [SEL_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [SEL_W-1:0] ALU_AND  = 2'b01;
    localparam logic [SEL_W-1:0] ALU_NOT  = 2'b10;
    localparam logic [SEL_W-1:0] ALU_PASS = 2'b11;

    typedef struct packed {
        logic             ena_marm;
        logic             ena_pc;
        logic             ena_mdr;
        logic             ena_alu;
        logic             ld_pc;
        logic             ld_ir;
        logic             ld_mar;
        logic             ld_mdr;
        logic             reg_we;
        logic             flag_we;
        logic [SEL_W-1:0] sel_pc;
        logic             sel_eab1;
        logic [SEL_W-1:0] sel_eab2;
        logic             sel_marm;
        logic             sel_mdr;
        logic [SEL_W-1:0] alu_ctrl;
        logic [REG_W-1:0] dr;
        logic [REG_W-1:0] sr1;
        logic [REG_W-1:0] sr2;
        logic             mem_en;
        logic             mem_we;
        logic             halted;
    } ctrl_t;

    // Branch condition: any requested flag that is currently set.
    function automatic logic br_taken(input logic [2:0] nzp_mask,
                                      input logic n, input logic z, input logic p);
        return |(nzp_mask & {n, z, p});
    endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational output decoder for the LC3 control unit.
// Ports:
//   state_i   current micro-state
//   ir_i      instruction register
//   mem_rdy_i memory handshake (only steers ldMDR in read-wait states)
//   ctrl_o    full control bundle for the datapath
import lc3_pkg::*;

module lc3_ctrl_decode (
    input  state_e            state_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic              mem_rdy_i,
    output ctrl_t             ctrl_o
);

    logic [OPCODE_W-1:0] opcode;
    logic                unused_ir;

    assign opcode    = ir_i[15:12];
    assign unused_ir = ^ir_i[5:3];

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH0: begin
                ctrl_o.ena_pc = 1'b1;
                ctrl_o.ld_mar = 1'b1;
                ctrl_o.ld_pc  = 1'b1;
                ctrl_o.sel_pc = SELPC_INC;
            end
            // Read-wait states: MDR captures memory data on the completing cycle.
            S_FETCH1, S_IND_RD, S_MEM_RD: begin
                ctrl_o.mem_en  = 1'b1;
                ctrl_o.sel_mdr = 1'b1;
                ctrl_o.ld_mdr  = mem_rdy_i;
            end
            S_FETCH2: begin
                ctrl_o.ena_mdr = 1'b1;
                ctrl_o.ld_ir   = 1'b1;
            end
            S_ALU: begin
                ctrl_o.ena_alu = 1'b1;
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.flag_we = 1'b1;
                ctrl_o.dr      = ir_i[11:9];
                ctrl_o.sr1     = ir_i[8:6];
                ctrl_o.sr2     = ir_i[2:0];
                if (opcode == OP_ADD) begin
                    ctrl_o.alu_ctrl = ALU_ADD;
                end else if (opcode == OP_AND) begin
                    ctrl_o.alu_ctrl = ALU_AND;
                end else begin
                    ctrl_o.alu_ctrl = ALU_NOT;
                end
            end
            S_BR: begin
                ctrl_o.sel_eab1 = 1'b0;
                ctrl_o.sel_eab2 = EAB2_OFF9;
                ctrl_o.sel_pc   = SELPC_EAB;
                ctrl_o.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl_o.sr1      = ir_i[8:6];
                ctrl_o.sel_eab1 = 1'b1;
                ctrl_o.sel_eab2 = EAB2_ZERO;
                ctrl_o.sel_pc   = SELPC_EAB;
                ctrl_o.ld_pc    = 1'b1;
            end
            // Save return address (current PC) into R7.
            S_JSR0: begin
                ctrl_o.ena_pc = 1'b1;
                ctrl_o.reg_we = 1'b1;
                ctrl_o.dr     = 3'd7;
            end
            // IR[11] selects JSR (PC + offset11) vs JSRR (base register).
            S_JSR1: begin
                if (ir_i[11]) begin
                    ctrl_o.sel_eab1 = 1'b0;
                    ctrl_o.sel_eab2 = EAB2_OFF11;
                end else begin
                    ctrl_o.sel_eab1 = 1'b1;
                    ctrl_o.sr1      = ir_i[8:6];
                    ctrl_o.sel_eab2 = EAB2_ZERO;
                end
                ctrl_o.sel_pc = SELPC_EAB;
                ctrl_o.ld_pc  = 1'b1;
            end
            S_LEA: begin
                ctrl_o.ena_marm = 1'b1;
                ctrl_o.sel_marm = 1'b0;
                ctrl_o.sel_eab1 = 1'b0;
                ctrl_o.sel_eab2 = EAB2_OFF9;
                ctrl_o.reg_we   = 1'b1;
                ctrl_o.dr       = ir_i[11:9];
            end
            // Effective address: base+offset6 for LDR/STR, PC+offset9 otherwise.
            S_ADDR: begin
                ctrl_o.ena_marm = 1'b1;
                ctrl_o.sel_marm = 1'b0;
                ctrl_o.ld_mar   = 1'b1;
                if (opcode == OP_LDR || opcode == OP_STR) begin
                    ctrl_o.sel_eab1 = 1'b1;
                    ctrl_o.sr1      = ir_i[8:6];
                    ctrl_o.sel_eab2 = EAB2_OFF6;
                end else begin
                    ctrl_o.sel_eab1 = 1'b0;
                    ctrl_o.sel_eab2 = EAB2_OFF9;
                end
            end
            S_IND_MAR: begin
                ctrl_o.ena_mdr = 1'b1;
                ctrl_o.ld_mar  = 1'b1;
            end
            S_LD_WB: begin
                ctrl_o.ena_mdr = 1'b1;
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.flag_we = 1'b1;
                ctrl_o.dr      = ir_i[11:9];
            end
            // Store data goes through the ALU in pass-A mode onto the bus.
            S_ST_MDR: begin
                ctrl_o.sr1      = ir_i[11:9];
                ctrl_o.alu_ctrl = ALU_PASS;
                ctrl_o.ena_alu  = 1'b1;
                ctrl_o.sel_mdr  = 1'b0;
                ctrl_o.ld_mdr   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_en = 1'b1;
                ctrl_o.mem_we = 1'b1;
            end
            S_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC3 multicycle control unit: micro-state register, next-state logic and
// the combinational output decoder.
// Ports:
//   clk, rst            clock, async active-low reset
//   IR, N, Z, P         instruction register and condition flags
//   mem_rdy             memory completes the current access
//   ena*                bus drive enables (one-hot or zero)
//   ld*, regWE, flagWE  register/flag load strobes
//   sel*, ALUctrl       datapath mux and ALU selects
//   DR, SR1, SR2        register file addresses
//   memEN, memWE        memory request / write
//   halted              controller stopped in HALT
import lc3_pkg::*;

module lc3_ctrl_fsm (
    input  logic             clk,
    input  logic             rst,
    input  logic [IR_W-1:0]  IR,
    input  logic             N,
    input  logic             Z,
    input  logic             P,
    input  logic             mem_rdy,
    output logic             enaMARM,
    output logic             enaPC,
    output logic             enaMDR,
    output logic             enaALU,
    output logic             ldPC,
    output logic             ldIR,
    output logic             ldMAR,
    output logic             ldMDR,
    output logic             regWE,
    output logic             flagWE,
    output logic [SEL_W-1:0] selPC,
    output logic             selEAB1,
    output logic [SEL_W-1:0] selEAB2,
    output logic             selMARM,
    output logic             selMDR,
    output logic [SEL_W-1:0] ALUctrl,
    output logic [REG_W-1:0] DR,
    output logic [REG_W-1:0] SR1,
    output logic [REG_W-1:0] SR2,
    output logic             memEN,
    output logic             memWE,
    output logic             halted
);

    state_e              state_q, state_d;
    logic                run_q;
    logic [OPCODE_W-1:0] opcode;
    ctrl_t               ctrl;

    assign opcode = IR[15:12];

    // run_q holds IDLE for one extra edge after reset release, so the first
    // FETCH0 lands on the second rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run_q) state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: if (mem_rdy) state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: state_d = S_ALU;
                    OP_BR:  state_d = br_taken(IR[11:9], N, Z, P) ? S_BR : S_FETCH0;
                    OP_JMP: state_d = S_JMP;
                    OP_JSR: state_d = S_JSR0;
                    OP_LEA: state_d = S_LEA;
                    OP_LD, OP_LDI, OP_ST, OP_STI, OP_LDR, OP_STR: state_d = S_ADDR;
                    default: state_d = S_HALT;
                endcase
            end
            S_ALU, S_BR, S_JMP, S_JSR1, S_LEA, S_LD_WB: state_d = S_FETCH0;
            S_JSR0: state_d = S_JSR1;
            S_ADDR: begin
                if (opcode == OP_LDI || opcode == OP_STI) begin
                    state_d = S_IND_RD;
                end else if (opcode == OP_LD || opcode == OP_LDR) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_ST_MDR;
                end
            end
            S_IND_RD:  if (mem_rdy) state_d = S_IND_MAR;
            S_IND_MAR: state_d = (opcode == OP_LDI) ? S_MEM_RD : S_ST_MDR;
            S_MEM_RD:  if (mem_rdy) state_d = S_LD_WB;
            S_ST_MDR:  state_d = S_MEM_WR;
            S_MEM_WR:  if (mem_rdy) state_d = S_FETCH0;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    lc3_ctrl_decode u_decode (
        .state_i   (state_q),
        .ir_i      (IR),
        .mem_rdy_i (mem_rdy),
        .ctrl_o    (ctrl)
    );

    assign enaMARM = ctrl.ena_marm;
    assign enaPC   = ctrl.ena_pc;
    assign enaMDR  = ctrl.ena_mdr;
    assign enaALU  = ctrl.ena_alu;
    assign ldPC    = ctrl.ld_pc;
    assign ldIR    = ctrl.ld_ir;
    assign ldMAR   = ctrl.ld_mar;
    assign ldMDR   = ctrl.ld_mdr;
    assign regWE   = ctrl.reg_we;
    assign flagWE  = ctrl.flag_we;
    assign selPC   = ctrl.sel_pc;
    assign selEAB1 = ctrl.sel_eab1;
    assign selEAB2 = ctrl.sel_eab2;
    assign selMARM = ctrl.sel_marm;
    assign selMDR  = ctrl.sel_mdr;
    assign ALUctrl = ctrl.alu_ctrl;
    assign DR      = ctrl.dr;
    assign SR1     = ctrl.sr1;
    assign SR2     = ctrl.sr2;
    assign memEN   = ctrl.mem_en;
    assign memWE   = ctrl.mem_we;
    assign halted  = ctrl.halted;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Self-checking bench for lc3_ctrl_fsm: an instruction-level model expands
// each instruction into its expected per-cycle control words, which are
// compared against the DUT every cycle; directed cases pin key literals.
module tb_lc3_ctrl_fsm;

    typedef struct packed {
        logic       enaMARM, enaPC, enaMDR, enaALU;
        logic       ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
        logic [1:0] selPC;
        logic       selEAB1;
        logic [1:0] selEAB2;
        logic       selMARM, selMDR;
        logic [1:0] ALUctrl;
        logic [2:0] DR, SR1, SR2;
        logic       memEN, memWE, halted;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IR;
    logic        N, Z, P, mem_rdy;
    logic        enaMARM, enaPC, enaMDR, enaALU, ldPC, ldIR, ldMAR, ldMDR;
    logic        regWE, flagWE, selEAB1, selMARM, selMDR, memEN, memWE, halted;
    logic [1:0]  selPC, selEAB2, ALUctrl;
    logic [2:0]  DR, SR1, SR2;

    int n_checks = 0;
    int n_errors = 0;

    // Expected per-cycle steps; kind 0 = single cycle, 1 = read wait, 2 = write wait.
    ctl_t q_out[$];
    int   q_kind[$];
    ctl_t log_a[0:255];

    always #5 clk = ~clk;

    lc3_ctrl_fsm dut (
        .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .mem_rdy(mem_rdy),
        .enaMARM(enaMARM), .enaPC(enaPC), .enaMDR(enaMDR), .enaALU(enaALU),
        .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .regWE(regWE), .flagWE(flagWE), .selPC(selPC), .selEAB1(selEAB1),
        .selEAB2(selEAB2), .selMARM(selMARM), .selMDR(selMDR), .ALUctrl(ALUctrl),
        .DR(DR), .SR1(SR1), .SR2(SR2), .memEN(memEN), .memWE(memWE), .halted(halted)
    );

    function automatic ctl_t dut_vec();
        ctl_t v;
        v.enaMARM = enaMARM; v.enaPC = enaPC; v.enaMDR = enaMDR; v.enaALU = enaALU;
        v.ldPC = ldPC; v.ldIR = ldIR; v.ldMAR = ldMAR; v.ldMDR = ldMDR;
        v.regWE = regWE; v.flagWE = flagWE; v.selPC = selPC; v.selEAB1 = selEAB1;
        v.selEAB2 = selEAB2; v.selMARM = selMARM; v.selMDR = selMDR;
        v.ALUctrl = ALUctrl; v.DR = DR; v.SR1 = SR1; v.SR2 = SR2;
        v.memEN = memEN; v.memWE = memWE; v.halted = halted;
        return v;
    endfunction

    function automatic void chk(string nm, ctl_t got, ctl_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endfunction

    function automatic void chk_int(string nm, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endfunction

    function automatic void push(ctl_t c, int kind);
        q_out.push_back(c);
        q_kind.push_back(kind);
    endfunction

    // Expand one instruction into its expected sequence of control words.
    function automatic void build(logic [15:0] ir, logic n, logic z, logic p);
        ctl_t c;
        ctl_t rd;
        logic [3:0] op;
        op = ir[15:12];
        q_out.delete();
        q_kind.delete();
        c = '0; c.enaPC = 1; c.ldMAR = 1; c.ldPC = 1; push(c, 0);
        rd = '0; rd.memEN = 1; rd.selMDR = 1;
        push(rd, 1);
        c = '0; c.enaMDR = 1; c.ldIR = 1; push(c, 0);
        c = '0; push(c, 0);
        case (op)
            4'h1, 4'h5, 4'h9: begin
                c = '0; c.enaALU = 1; c.regWE = 1; c.flagWE = 1;
                c.DR = ir[11:9]; c.SR1 = ir[8:6]; c.SR2 = ir[2:0];
                c.ALUctrl = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
                push(c, 0);
            end
            4'h0: begin
                if ((ir[11] && n) || (ir[10] && z) || (ir[9] && p)) begin
                    c = '0; c.selEAB2 = 2'd2; c.selPC = 2'd1; c.ldPC = 1; push(c, 0);
                end
            end
            4'hC: begin
                c = '0; c.SR1 = ir[8:6]; c.selEAB1 = 1; c.selPC = 2'd1; c.ldPC = 1;
                push(c, 0);
            end
            4'h4: begin
                c = '0; c.enaPC = 1; c.regWE = 1; c.DR = 3'd7; push(c, 0);
                c = '0; c.selPC = 2'd1; c.ldPC = 1;
                if (ir[11]) c.selEAB2 = 2'd3;
                else begin c.selEAB1 = 1; c.SR1 = ir[8:6]; end
                push(c, 0);
            end
            4'hE: begin
                c = '0; c.enaMARM = 1; c.selEAB2 = 2'd2; c.regWE = 1; c.DR = ir[11:9];
                push(c, 0);
            end
            4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB: begin
                c = '0; c.enaMARM = 1; c.ldMAR = 1;
                if (op == 4'h6 || op == 4'h7) begin
                    c.selEAB1 = 1; c.SR1 = ir[8:6]; c.selEAB2 = 2'd1;
                end else begin
                    c.selEAB2 = 2'd2;
                end
                push(c, 0);
                if (op == 4'hA || op == 4'hB) begin
                    push(rd, 1);
                    c = '0; c.enaMDR = 1; c.ldMAR = 1; push(c, 0);
                end
                if (op == 4'h2 || op == 4'h6 || op == 4'hA) begin
                    push(rd, 1);
                    c = '0; c.enaMDR = 1; c.regWE = 1; c.flagWE = 1; c.DR = ir[11:9];
                    push(c, 0);
                end else begin
                    c = '0; c.SR1 = ir[11:9]; c.ALUctrl = 2'd3; c.enaALU = 1; c.ldMDR = 1;
                    push(c, 0);
                    c = '0; c.memEN = 1; c.memWE = 1; push(c, 2);
                end
            end
            default: begin
                c = '0; c.halted = 1; push(c, 0);
            end
        endcase
    endfunction

    // Called shortly after a negedge with the DUT in FETCH0. lowcnt < 0 gives
    // random wait lengths; otherwise each access sees lowcnt low cycles.
    task automatic run_instr(input logic [15:0] ir, input logic n, input logic z,
                             input logic p, input int lowcnt, output int cycles);
        ctl_t exp;
        ctl_t got;
        int   wcnt;
        build(ir, n, z, p);
        IR = ir; N = n; Z = z; P = p;
        cycles = 0;
        wcnt = 0;
        while (q_out.size() > 0 && cycles < 200) begin
            if (q_kind[0] != 0) begin
                if (lowcnt < 0) mem_rdy = (wcnt >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                else            mem_rdy = (wcnt >= lowcnt);
            end else begin
                mem_rdy = 1'($urandom_range(0, 1));
            end
            #1;
            exp = q_out[0];
            if (q_kind[0] == 1) exp.ldMDR = mem_rdy;
            got = dut_vec();
            chk("ctrl_word", got, exp);
            chk_int("bus_excl", int'($countones({enaMARM, enaPC, enaMDR, enaALU}) <= 1), 1);
            log_a[cycles] = got;
            if (q_kind[0] != 0 && !mem_rdy) begin
                wcnt++;
            end else begin
                void'(q_out.pop_front());
                void'(q_kind.pop_front());
                wcnt = 0;
            end
            cycles++;
            if (q_out.size() > 0) @(negedge clk);
        end
        if (cycles >= 200) chk_int("instr_timeout", cycles, -1);
        // Halted instructions stay in place; others move on to the next FETCH0.
        @(negedge clk);
    endtask

    task automatic release_reset();
        ctl_t f0;
        f0 = '0; f0.enaPC = 1; f0.ldMAR = 1; f0.ldPC = 1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("idle_1st_edge", dut_vec(), '0);
        @(negedge clk); #1;
        chk("fetch0_2nd_edge", dut_vec(), f0);
    endtask

    initial begin
        int   cyc;
        int   cnt;
        ctl_t h;
        logic [15:0] ir;
        logic [3:0]  ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                  4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};

        rst = 1'b0; IR = '0; N = 0; Z = 0; P = 0; mem_rdy = 1'b1;
        #3;
        chk("reset_zero", dut_vec(), '0);
        @(negedge clk); #1;
        chk("reset_zero_clocked", dut_vec(), '0);
        release_reset();

        // Reset in the middle of a pending fetch read.
        mem_rdy = 1'b0;
        @(negedge clk); #1;
        chk_int("fetch1_memEN", int'(memEN), 1);
        #1 rst = 1'b0;
        #1;
        chk("async_reset_zero", dut_vec(), '0);
        mem_rdy = 1'b1;
        @(negedge clk); #1;
        chk("reset_hold_zero", dut_vec(), '0);
        release_reset();

        // ADD R1,R2,R3
        run_instr(16'h1283, 0, 0, 0, 0, cyc);
        chk_int("add_cycles", cyc, 5);
        chk_int("add_dr", int'(log_a[4].DR), 1);
        chk_int("add_sr1", int'(log_a[4].SR1), 2);
        chk_int("add_sr2", int'(log_a[4].SR2), 3);
        chk_int("add_aluctrl", int'(log_a[4].ALUctrl), 0);
        chk_int("add_we", int'({log_a[4].regWE, log_a[4].flagWE}), 3);

        // BRnp, not taken with Z.
        run_instr(16'h0A05, 0, 1, 0, 0, cyc);
        chk_int("br_nt_cycles", cyc, 4);
        chk_int("br_nt_ldpc", int'(log_a[1].ldPC | log_a[2].ldPC | log_a[3].ldPC), 0);

        // BRnp, taken with N.
        run_instr(16'h0A05, 1, 0, 0, 0, cyc);
        chk_int("br_t_cycles", cyc, 5);
        chk_int("br_t_selpc", int'(log_a[4].selPC), 1);
        chk_int("br_t_seleab2", int'(log_a[4].selEAB2), 2);
        chk_int("br_t_ldpc", int'(log_a[4].ldPC), 1);

        // LDI R2 with three low mem_rdy cycles per access.
        run_instr(16'hA405, 0, 0, 0, 3, cyc);
        chk_int("ldi_cycles", cyc, 18);
        cnt = 0;
        for (int i = 0; i < cyc; i++) cnt += int'(log_a[i].memEN);
        chk_int("ldi_memen_cycles", cnt, 12);
        chk_int("ldi_wb", int'({log_a[cyc-1].enaMDR, log_a[cyc-1].regWE}), 3);

        // STR R3, R2, #1
        run_instr(16'h7681, 0, 0, 0, 0, cyc);
        chk_int("str_cycles", cyc, 7);
        chk_int("str_addr_sel", int'({log_a[4].selEAB1, log_a[4].selEAB2}), 3'b101);
        chk_int("str_stmdr", int'({log_a[5].selMDR, log_a[5].ldMDR}), 1);
        chk_int("str_stmdr_sr1", int'(log_a[5].SR1), 3);
        chk_int("str_memwr", int'(log_a[6].memWE), 1);

        // JSR and LEA lengths.
        run_instr(16'h4803, 0, 0, 0, 0, cyc);
        chk_int("jsr_cycles", cyc, 6);
        run_instr(16'hE20A, 0, 0, 0, 0, cyc);
        chk_int("lea_cycles", cyc, 5);

        // Random legal instruction stream with random memory latency.
        for (int k = 0; k < 300; k++) begin
            ir = 16'($urandom);
            ir[15:12] = ops[$urandom_range(0, 12)];
            if (ir[15:12] == 4'h4 && !ir[11] && ir[8:6] == 3'd7) ir[8:6] = 3'd0;
            run_instr(ir, 1'($urandom), 1'($urandom), 1'($urandom), -1, cyc);
        end

        // TRAP halts until reset.
        run_instr(16'hF025, 0, 0, 0, 0, cyc);
        chk_int("trap_cycles", cyc, 5);
        h = '0; h.halted = 1;
        for (int k = 0; k < 20; k++) begin
            mem_rdy = 1'($urandom);
            IR = 16'($urandom);
            #1;
            chk("halt_hold", dut_vec(), h);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
